fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the pipelined RV32I core with synchronous BRAM instruction memory (1-cycle read latency). Owns PCF, drives the BRAM address, and presents InstrD/PCD/PCPlus4D/ValidD to decode. Consumes StallF, StallD and FlushD from the hazard unit, and PCSrcE/PCTargetE from execute. Contains a hold buffer so InstrD stays stable while decode is stalled, even though the BRAM output keeps changing.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PCF value on reset
NOP_INSTR, 32'h0000_0013, addi x0,x0,0 shown on InstrD when the decode slot is invalid

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
StallF  input  1  hold PCF
StallD  input  1  hold IF/ID register
FlushD  input  1  squash IF/ID register to bubble
PCSrcE  input  1  taken branch/jump redirect from execute
PCTargetE  input  XLEN  redirect target
imem_addr  output  XLEN  BRAM byte address, equal to PCF
imem_en  output  1  BRAM read enable, constant 1 outside reset
imem_rdata  input  32  BRAM data; holds mem[address registered at previous edge]
InstrD  output  32  instruction in decode
PCD  output  XLEN  PC of InstrD
PCPlus4D  output  XLEN  PCD+4
ValidD  output  1  decode slot holds a real instruction

Behaviour:
- Reset (sampled at the edge): PCF=RESET_PC, PCD=0, PCPlus4D=0, ValidD=0, hold_valid=0, hold_instr=0. InstrD=NOP_INSTR. imem_en=0 during reset.
- PCF next-state, in priority order: reset; PCSrcE -> {PCTargetE[XLEN-1:2],2'b00} (overrides StallF); StallF -> hold; else PCF+4, wrapping modulo 2^XLEN. PCF[1:0] is always 0.
- IF/ID next-state, in priority order: reset; FlushD -> PCD=0, PCPlus4D=0, ValidD=0, hold cleared (overrides StallD); StallD -> hold all; else PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
- Alignment rule: the BRAM registers mem[PCF] on the same edge that PCD<=PCF, so imem_rdata corresponds to PCD in the following cycle. Fetch introduces 0 bubbles on the sequential path.
- Hold buffer:
  - On an edge with StallD=1, FlushD=0, hold_valid=0: capture hold_instr<=imem_rdata and set hold_valid=1.
  - While StallD stays high: retain hold_instr.
  - On an edge with StallD=0 or FlushD=1: clear hold_valid.
  - Reason: during a stall PCF is held, so the BRAM re-reads mem[PCF], not mem[PCD].
- InstrD (combinational):
  - ValidD=0 -> NOP_INSTR
  - else hold_valid=1 -> hold_instr
  - else imem_rdata
- Redirect timing: PCSrcE high in cycle t. At edge t+1, PCF=target and the decode slot is a bubble (hazard unit drives FlushD). At edge t+2, PCD=target and InstrD=mem[target]. Exactly 1 decode bubble.
- Multi-cycle stalls (load-use 2 cycles, branch stalls up to 2): InstrD, PCD and ValidD stay constant for every stalled cycle. On release, decode advances to PCF with no lost or duplicated instruction.
- StallD=1 with StallF=0 is illegal (the hazard unit never produces it). The bench asserts on it; the RTL need not define it.
- Reset asserted mid-stall or mid-redirect: reset wins. The first edge after deassert loads PCD=RESET_PC with ValidD=1.

Decomposition:
- Shared package riscv_pkg: XLEN, RESET_PC default, NOP_INSTR constant.
- One sub-module, fetch_hold_buf: the hold_valid/hold_instr register and the InstrD mux. Inputs: StallD, FlushD, ValidD, imem_rdata.
- PC register and IF/ID register stay in the top level.

Test Plan:
- Reset release, BRAM preloaded mem[0]=0x00500093, mem[4]=0x00100113 -> cycle 1: PCD=0, InstrD=0x00500093, ValidD=1. Cycle 2: PCD=4, InstrD=0x00100113.
- StallF=StallD=1 for 2 cycles while PCD=8 (mem[8]=0x0000A183, mem[12]=0x00318233) -> InstrD=0x0000A183 and PCD=8 for both cycles. After release: PCD=12, InstrD=0x00318233.
- PCSrcE=1, PCTargetE=0x40, with FlushD=1, at PCF=0x10 -> next cycle PCF=0x40, ValidD=0, InstrD=0x00000013. Following cycle: PCD=0x40, InstrD=mem[0x40].
- PCSrcE=1 and FlushD=1 together with StallF=StallD=1 -> redirect wins: PCF=target, hold cleared, no stale instruction reaches decode.
- PCTargetE=0x00000046 -> PCF=0x44. PCF=0xFFFFFFFC with no stall -> PCF wraps to 0x00000000 and PCPlus4D=0x00000000.
- Reset asserted during a stall with hold_valid=1 -> hold_valid=0, ValidD=0, PCF=RESET_PC. Clean restart at mem[RESET_PC].

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the pipelined RV32I core.
//   XLEN             - datapath / PC width
//   RESET_PC_DEFAULT - default value of PCF after reset
//   NOP_INSTR        - addi x0,x0,0, shown in decode when the slot is empty
//   align_pc()       - clears the two byte-offset bits of a PC value
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // Only the word-address bits of a target are kept; instructions are
  // always word aligned in this core.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Decode-side instruction hold buffer and InstrD select.
// While decode is stalled the PC is frozen, so the BRAM re-reads mem[PCF]
// rather than the instruction that belongs to PCD. The first stalled edge
// snapshots the BRAM output, and decode shows that snapshot until the
// stall ends or the slot is flushed.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   StallD      - decode stall from the hazard unit
//   FlushD      - decode flush from the hazard unit
//   ValidD      - decode slot holds a real instruction
//   imem_rdata  - BRAM read data
//   InstrD      - instruction presented to decode
module fetch_hold_buf
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        ValidD,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD
);

  logic        hold_valid_reg;
  logic [31:0] hold_instr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_reg <= 1'b0;
      hold_instr_reg <= 32'h0;
    end else if (FlushD) begin
      hold_valid_reg <= 1'b0;
    end else if (StallD) begin
      // Capture only on the first stalled edge; later edges would pick up
      // mem[PCF] instead of the decode instruction.
      if (!hold_valid_reg) begin
        hold_instr_reg <= imem_rdata;
        hold_valid_reg <= 1'b1;
      end
    end else begin
      hold_valid_reg <= 1'b0;
    end
  end

  always_comb begin
    InstrD = imem_rdata;
    if (!ValidD) begin
      InstrD = NOP;
    end else if (hold_valid_reg) begin
      InstrD = hold_instr_reg;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Owns PCF and drives it straight onto the synchronous BRAM address. The
// BRAM registers mem[PCF] on the same edge that PCD takes PCF, so the BRAM
// output lines up with PCD one cycle later with no fetch bubble.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   StallF, StallD    - hold PCF / hold IF/ID register
//   FlushD            - squash IF/ID register to a bubble
//   PCSrcE, PCTargetE - taken branch/jump redirect from execute
//   imem_addr/en      - BRAM byte address (=PCF) and read enable
//   imem_rdata        - BRAM read data
//   InstrD, PCD, PCPlus4D, ValidD - decode slot contents
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN_P    = XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0]     NOP       = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  logic [XLEN-1:0] pcf_reg;
  logic [XLEN-1:0] pcf_next;
  logic [XLEN-1:0] pcf_plus4;
  logic [XLEN-1:0] pcd_reg;
  logic [XLEN-1:0] pcplus4d_reg;
  logic            validd_reg;
  logic            target_lsb_unused;
  logic            width_unused;

  // Byte-offset bits of the redirect target are dropped by align_pc().
  assign target_lsb_unused = ^PCTargetE[1:0];
  assign width_unused      = (XLEN_P != XLEN);

  // Natural wrap modulo 2^XLEN.
  assign pcf_plus4 = pcf_reg + XLEN'(4);

  // Redirect beats StallF: a taken branch must leave the stalled path.
  always_comb begin
    pcf_next = pcf_plus4;
    if (PCSrcE) begin
      pcf_next = align_pc(PCTargetE);
    end else if (StallF) begin
      pcf_next = pcf_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_reg <= RESET_PC;
    end else begin
      pcf_reg <= pcf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcd_reg      <= '0;
      pcplus4d_reg <= '0;
      validd_reg   <= 1'b0;
    end else if (FlushD) begin
      pcd_reg      <= '0;
      pcplus4d_reg <= '0;
      validd_reg   <= 1'b0;
    end else if (!StallD) begin
      pcd_reg      <= pcf_reg;
      pcplus4d_reg <= pcf_plus4;
      validd_reg   <= 1'b1;
    end
  end

  assign imem_addr = pcf_reg;
  assign imem_en   = ~reset;
  assign PCD       = pcd_reg;
  assign PCPlus4D  = pcplus4d_reg;
  assign ValidD    = validd_reg;

  fetch_hold_buf #(
    .NOP (NOP)
  ) u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .ValidD     (validd_reg),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle synchronous BRAM model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  logic [31:0] mem [0:255];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr[9:2]];
  end

  // StallD without StallF is never produced by the hazard unit.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      assert (!(StallD && !StallF)) else $error("illegal StallD=1 with StallF=0");
    end
  end

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d: PCF=%h PCD=%h PCPlus4D=%h ValidD=%0b InstrD=%h",
             cyc, imem_addr, PCD, PCPlus4D, ValidD, InstrD);
  endtask

  task automatic set_ctl(input logic sf, input logic sd, input logic fd,
                         input logic ps, input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pcf, input logic [31:0] pcd,
                         input logic [31:0] pc4, input logic v, input logic [31:0] instr);
    check({tag, ".PCF"},    imem_addr, pcf);
    check({tag, ".PCD"},    PCD, pcd);
    check({tag, ".PCP4D"},  PCPlus4D, pc4);
    check({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, v});
    check({tag, ".InstrD"}, InstrD, instr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0000_A183;
    mem[3] = 32'h0031_8233;
    imem_rdata = 32'h0;
    reset = 1'b1;
    set_ctl(0, 0, 0, 0, 32'h0);

    // Reset state
    step(); step();
    check_d("rst", 32'h0, 32'h0, 32'h0, 0, 32'h0000_0013);
    check("rst.imem_en", {31'b0, imem_en}, 32'h0);
    reset = 1'b0;

    // Sequential fetch, no bubble
    step(); check_d("seq0", 32'h4, 32'h0, 32'h4, 1, 32'h0050_0093);
    check("seq0.imem_en", {31'b0, imem_en}, 32'h1);
    step(); check_d("seq1", 32'h8, 32'h4, 32'h8, 1, 32'h0010_0113);
    step(); check_d("seq2", 32'hC, 32'h8, 32'hC, 1, 32'h0000_A183);

    // Two-cycle stall holds decode
    set_ctl(1, 1, 0, 0, 32'h0);
    step(); check_d("stall1", 32'hC, 32'h8, 32'hC, 1, 32'h0000_A183);
    step(); check_d("stall2", 32'hC, 32'h8, 32'hC, 1, 32'h0000_A183);
    set_ctl(0, 0, 0, 0, 32'h0);
    step(); check_d("release", 32'h10, 32'hC, 32'h10, 1, 32'h0031_8233);

    // Redirect with flush: exactly one bubble
    set_ctl(0, 0, 1, 1, 32'h40);
    step(); check_d("redir", 32'h40, 32'h0, 32'h0, 0, 32'h0000_0013);
    set_ctl(0, 0, 0, 0, 32'h0);
    step(); check_d("redir_tgt", 32'h44, 32'h40, 32'h44, 1, 32'hA000_0010);

    // Redirect during a stall with hold buffer loaded
    set_ctl(1, 1, 0, 0, 32'h0);
    step(); check_d("hold", 32'h44, 32'h40, 32'h44, 1, 32'hA000_0010);
    set_ctl(1, 1, 1, 1, 32'h80);
    step(); check_d("stall_redir", 32'h80, 32'h0, 32'h0, 0, 32'h0000_0013);
    set_ctl(0, 0, 0, 0, 32'h0);
    step(); check_d("stall_redir_tgt", 32'h84, 32'h80, 32'h84, 1, 32'hA000_0020);

    // Misaligned target is word aligned
    set_ctl(0, 0, 1, 1, 32'h46);
    step(); check_d("align", 32'h44, 32'h0, 32'h0, 0, 32'h0000_0013);
    set_ctl(0, 0, 0, 0, 32'h0);
    step(); check_d("align_tgt", 32'h48, 32'h44, 32'h48, 1, 32'hA000_0011);

    // PC wrap at top of address space
    set_ctl(0, 0, 1, 1, 32'hFFFF_FFFC);
    step(); check_d("wrap_redir", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'h0000_0013);
    set_ctl(0, 0, 0, 0, 32'h0);
    step(); check_d("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 32'hA000_00FF);
    step(); check_d("wrap1", 32'h4, 32'h0, 32'h4, 1, 32'h0050_0093);
    step(); check_d("wrap2", 32'h8, 32'h4, 32'h8, 1, 32'h0010_0113);
    step(); check_d("wrap3", 32'hC, 32'h8, 32'hC, 1, 32'h0000_A183);

    // Reset during a stall with the hold buffer loaded
    set_ctl(1, 1, 0, 0, 32'h0);
    step(); check_d("pre_rst_hold", 32'hC, 32'h8, 32'hC, 1, 32'h0000_A183);
    reset = 1'b1;
    step(); check_d("rst_stall", 32'h0, 32'h0, 32'h0, 0, 32'h0000_0013);
    reset = 1'b0;
    set_ctl(0, 0, 0, 0, 32'h0);
    step(); check_d("restart", 32'h4, 32'h0, 32'h4, 1, 32'h0050_0093);
    step(); check_d("restart1", 32'h8, 32'h4, 32'h8, 1, 32'h0010_0113);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
